// File: rtl/lock_attempt_controller.sv
// Keypad-to-lock sequencer: forwards code bits, samples the verdict,
// times the open door and enforces a failure lockout with alarm.
module lock_attempt_controller #(
  parameter int CODE_LEN       = 4,
  parameter int CHECK_WAIT     = 2,
  parameter int MAX_FAIL       = 3,
  parameter int UNLOCK_HOLD    = 50,
  parameter int LOCKOUT_CYCLES = 200,
  localparam int FW = $clog2(MAX_FAIL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_valid,
  input  logic          key_bit,
  input  logic          submit,
  input  logic          lock_unlocked,
  input  logic          lock_error,
  output logic          lock_bit,
  output logic          lock_bit_valid,
  output logic          lock_clear,
  output logic          ready,
  output logic          door_open,
  output logic          alarm,
  output logic [FW-1:0] fail_count
);

  localparam int T1   = (CHECK_WAIT > UNLOCK_HOLD) ?
                        CHECK_WAIT : UNLOCK_HOLD;
  localparam int TMAX = (T1 > LOCKOUT_CYCLES) ?
                        T1 : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(CODE_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, OPEN, CLEAR, LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] fail_q, fail_d, fail_inc;
  logic          fwd;

  logic lock_bit_q, lbv_q, clear_q;
  logic ready_q, door_q, alarm_q;

  assign fail_inc = (fail_q == FW'(MAX_FAIL)) ?
                    fail_q : fail_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    fail_d    = fail_q;
    fwd       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          fwd     = 1'b1;
          state_d = (CODE_LEN == 1) ? CHECK : ENTRY;
        end
      end
      ENTRY: begin
        if (submit) begin
          state_d = CLEAR;
        end else if (lock_error) begin
          fail_d  = fail_inc;
          state_d = CLEAR;
        end else if (key_valid) begin
          fwd       = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(CODE_LEN - 1))
            state_d = CHECK;
        end
      end
      CHECK: begin
        if (lock_error) begin
          fail_d  = fail_inc;
          state_d = CLEAR;
        end else if (timer_q == TW'(CHECK_WAIT - 1)) begin
          if (lock_unlocked) begin
            fail_d  = '0;
            state_d = OPEN;
          end else begin
            fail_d  = fail_inc;
            state_d = CLEAR;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      OPEN: begin
        if (submit || timer_q == TW'(UNLOCK_HOLD - 1))
          state_d = CLEAR;
        else
          timer_d = timer_q + 1'b1;
      end
      CLEAR: begin
        state_d = (fail_q == FW'(MAX_FAIL)) ?
                  LOCKOUT : IDLE;
      end
      LOCKOUT: begin
        if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
          fail_d  = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // first forwarded bit is already counted when ENTRY is entered
    if (state_d != state_q) begin
      timer_d   = '0;
      bit_cnt_d = (state_d == ENTRY) ? BW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      fail_q     <= '0;
      lock_bit_q <= 1'b0;
      lbv_q      <= 1'b0;
      clear_q    <= 1'b0;
      ready_q    <= 1'b1;
      door_q     <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      fail_q     <= fail_d;
      lock_bit_q <= fwd ? key_bit : lock_bit_q;
      lbv_q      <= fwd;
      clear_q    <= (state_d == CLEAR);
      ready_q    <= (state_d == IDLE) ||
                    (state_d == ENTRY);
      door_q     <= (state_d == OPEN);
      alarm_q    <= (state_d == LOCKOUT);
    end
  end

  assign lock_bit       = lock_bit_q;
  assign lock_bit_valid = lbv_q;
  assign lock_clear     = clear_q;
  assign ready          = ready_q;
  assign door_open      = door_q;
  assign alarm          = alarm_q;
  assign fail_count     = fail_q;

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Directed bench for lock_attempt_controller: unlock, hold, abort,
// failure counting, lockout and asynchronous reset.
module tb_lock_attempt_controller;

  logic       clk, reset;
  logic       key_valid, key_bit, submit;
  logic       lock_unlocked, lock_error;
  logic       lock_bit, lock_bit_valid, lock_clear;
  logic       ready, door_open, alarm;
  logic [1:0] fail_count;

  int errors = 0;
  int checks = 0;
  int bad;

  lock_attempt_controller dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_bit       (key_bit),
    .submit        (submit),
    .lock_unlocked (lock_unlocked),
    .lock_error    (lock_error),
    .lock_bit      (lock_bit),
    .lock_bit_valid(lock_bit_valid),
    .lock_clear    (lock_clear),
    .ready         (ready),
    .door_open     (door_open),
    .alarm         (alarm),
    .fail_count    (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic b);
    key_valid = 1'b1;
    key_bit   = b;
    step();
    key_valid = 1'b0;
    chk("fwd_valid", 32'(lock_bit_valid), 32'd1);
    chk("fwd_bit", 32'(lock_bit), 32'(b));
  endtask

  task automatic unlock_code();
    lock_unlocked = 1'b1;
    key(1'b1); key(1'b0); key(1'b1); key(1'b1);
    step();
    chk("check_wait_door", 32'(door_open), 32'd0);
    step();
    chk("door_rise", 32'(door_open), 32'd1);
    lock_unlocked = 1'b0;
  endtask

  task automatic close_door();
    submit = 1'b1;
    step();
    submit = 1'b0;
    chk("close_clear", 32'(lock_clear), 32'd1);
    step();
    chk("close_ready", 32'(ready), 32'd1);
  endtask

  task automatic fail_err();
    key(1'b1); key(1'b0);
    lock_error = 1'b1;
    step();
    lock_error = 1'b0;
    chk("err_clear", 32'(lock_clear), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_bit"},   32'(lock_bit), 32'd0);
    chk({tag, "_valid"}, 32'(lock_bit_valid), 32'd0);
    chk({tag, "_clear"}, 32'(lock_clear), 32'd0);
    chk({tag, "_door"},  32'(door_open), 32'd0);
    chk({tag, "_alarm"}, 32'(alarm), 32'd0);
    chk({tag, "_fail"},  32'(fail_count), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    key_valid = 1'b0; key_bit = 1'b0; submit = 1'b0;
    lock_unlocked = 1'b0; lock_error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    step();

    // full hold then timeout close
    unlock_code();
    bad = 0;
    for (int i = 1; i < 50; i++) begin
      step();
      if (!door_open || lock_clear) bad++;
    end
    chk("hold_50", 32'(bad), 32'd0);
    step();
    chk("hold_end_door", 32'(door_open), 32'd0);
    chk("hold_end_clear", 32'(lock_clear), 32'd1);
    chk("hold_end_ready", 32'(ready), 32'd0);
    step();
    chk("hold_idle_clear", 32'(lock_clear), 32'd0);
    chk("hold_idle_ready", 32'(ready), 32'd1);

    // submit on 5th open cycle
    unlock_code();
    repeat (4) step();
    chk("o5_door", 32'(door_open), 32'd1);
    submit = 1'b1;
    step();
    submit = 1'b0;
    chk("sub_door", 32'(door_open), 32'd0);
    chk("sub_clear", 32'(lock_clear), 32'd1);
    step();
    chk("sub_ready", 32'(ready), 32'd1);
    chk("sub_fail", 32'(fail_count), 32'd0);

    // three failures -> lockout
    for (int i = 1; i <= 3; i++) begin
      fail_err();
      chk("fail_step", 32'(fail_count), 32'(i));
      step();
    end
    chk("lock_alarm", 32'(alarm), 32'd1);
    chk("lock_ready", 32'(ready), 32'd0);
    bad = 0;
    for (int i = 1; i < 200; i++) begin
      key_valid = i[0];
      key_bit   = 1'b1;
      submit    = (i % 7 == 0);
      step();
      if (!alarm || lock_bit_valid || lock_clear) bad++;
    end
    key_valid = 1'b0;
    submit    = 1'b0;
    chk("lockout_200", 32'(bad), 32'd0);
    chk("lockout_fail", 32'(fail_count), 32'd3);
    step();
    chk("lockend_alarm", 32'(alarm), 32'd0);
    chk("lockend_fail", 32'(fail_count), 32'd0);
    chk("lockend_ready", 32'(ready), 32'd1);

    // two failures then success clears count
    fail_err(); step();
    fail_err(); step();
    chk("two_fail", 32'(fail_count), 32'd2);
    unlock_code();
    chk("ok_fail_zero", 32'(fail_count), 32'd0);
    close_door();
    lock_unlocked = 1'b0;
    key(1'b1); key(1'b0); key(1'b1); key(1'b1);
    step();
    step();
    chk("verdict0_clear", 32'(lock_clear), 32'd1);
    chk("verdict0_fail", 32'(fail_count), 32'd1);
    step();
    chk("verdict0_alarm", 32'(alarm), 32'd0);
    chk("verdict0_ready", 32'(ready), 32'd1);

    // error beats final key bit
    key(1'b1); key(1'b1); key(1'b1);
    key_valid = 1'b1;
    lock_error = 1'b1;
    step();
    key_valid = 1'b0;
    lock_error = 1'b0;
    chk("lastbit_err_valid", 32'(lock_bit_valid), 32'd0);
    chk("lastbit_err_clear", 32'(lock_clear), 32'd1);
    chk("lastbit_err_fail", 32'(fail_count), 32'd2);
    step();

    // submit beats key_valid: abort
    key(1'b0);
    key_valid = 1'b1;
    key_bit   = 1'b1;
    submit    = 1'b1;
    step();
    key_valid = 1'b0;
    submit    = 1'b0;
    chk("abort_valid", 32'(lock_bit_valid), 32'd0);
    chk("abort_clear", 32'(lock_clear), 32'd1);
    chk("abort_fail", 32'(fail_count), 32'd2);
    step();
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_clear_off", 32'(lock_clear), 32'd0);

    // reset mid-entry
    key(1'b1); key(1'b1);
    #2 reset = 1'b0;
    #1 check_reset_vals("rst_entry");
    #2 reset = 1'b1;
    step();
    chk("rst_entry_noclr", 32'(lock_clear), 32'd0);

    // reset mid-lockout
    for (int i = 0; i < 3; i++) begin
      fail_err();
      step();
    end
    repeat (10) step();
    chk("pre_rst_alarm", 32'(alarm), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_vals("rst_lock");
    #2 reset = 1'b1;
    step();
    chk("rst_lock_noclr", 32'(lock_clear), 32'd0);
    unlock_code();
    close_door();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/lock_attempt_controller.md
# lock_attempt_controller

Sequencing controller placed between the keypad front end and the digital lock FSM. It forwards entered code bits to the lock, waits for the verdict, and holds the door open for a bounded time. It counts consecutive failed attempts and enforces a timed lockout with alarm, and it clears the lock FSM back to idle after every attempt.

## Interface
- CODE_LEN, 4: bits per code attempt.
- CHECK_WAIT, 2: cycles between last forwarded bit and verdict sample (≥1).
- MAX_FAIL, 3: consecutive failures that trigger lockout (≥1).
- UNLOCK_HOLD, 50: cycles door stays open without submit (≥1).
- LOCKOUT_CYCLES, 200: lockout duration in cycles (≥1).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle pulse: key_bit is a new code bit.
- key_bit  in  1  entered code bit.
- submit  in  1  abort during entry / close door during open.
- lock_unlocked  in  1  lock FSM verdict: correct code.
- lock_error  in  1  lock FSM detected a wrong bit.
- lock_bit  out  1  bit forwarded to lock FSM.
- lock_bit_valid  out  1  one-cycle strobe qualifying lock_bit.
- lock_clear  out  1  one-cycle pulse returning lock FSM to idle.
- ready  out  1  controller accepts key bits (IDLE or ENTRY).
- door_open  out  1  high in OPEN.
- alarm  out  1  high in LOCKOUT.
- fail_count  out  $clog2(MAX_FAIL+1)  consecutive failures.

## Operation
- States: IDLE, ENTRY, CHECK, OPEN, CLEAR, LOCKOUT. Reset state IDLE.
- IDLE: key_valid → forward bit, bit_cnt=1, go ENTRY. If CODE_LEN=1, go CHECK. submit ignored.
- ENTRY: each key_valid forwards bit, bit_cnt++. When bit_cnt reaches CODE_LEN → CHECK.
- ENTRY: submit → CLEAR (abort). No failure is counted and the pending bit is dropped. submit beats key_valid in the same cycle.
- ENTRY: lock_error → failure. lock_error beats key_valid, including on the final bit.
- CHECK: wait CHECK_WAIT cycles, sample lock_unlocked on the last one.
  - Sample 1 → OPEN, fail_count=0.
  - Sample 0 or lock_error during CHECK → failure.
- Failure: fail_count++ (saturates at MAX_FAIL), go CLEAR.
- OPEN: hold timer counts UNLOCK_HOLD cycles. submit or expiry → CLEAR. key_valid ignored.
- CLEAR: lock_clear=1 for exactly one cycle. Next state is LOCKOUT if fail_count==MAX_FAIL, else IDLE.
- LOCKOUT: alarm=1 and timer counts LOCKOUT_CYCLES. key_valid and submit ignored, nothing forwarded. On expiry fail_count=0, go IDLE.
- Only a successful unlock or a lockout expiry zeroes fail_count. An abort leaves it unchanged.
- Timers and bit_cnt are sized with $clog2(param+1). They are zeroed on every state entry.

## Timing
- Reset (asynchronous, any state): state IDLE, all counters 0.
  - Outputs at reset: lock_bit=0, lock_bit_valid=0, lock_clear=0, door_open=0, alarm=0, fail_count=0, ready=1.
- All outputs are registered.
- Bit forwarding: key_valid at cycle N → lock_bit/lock_bit_valid at N+1.
- Verdict: last bit forwarded at N+1. CHECK spans N+1..N+CHECK_WAIT, and the sample is taken on cycle N+CHECK_WAIT. OPEN or CLEAR follows at N+CHECK_WAIT+1.
- OPEN lasts exactly UNLOCK_HOLD cycles if no submit arrives. submit at cycle M → CLEAR at M+1 → IDLE at M+2.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles, then IDLE. ready rises the same cycle IDLE is entered.
- lock_clear never coincides with lock_bit_valid.
- Reset deassertion mid-attempt: the controller restarts in IDLE. lock_clear is not pulsed; the downstream FSM is reset separately.

## Test plan
- Correct code 1,0,1,1 (lock_unlocked=1 at sample) → door_open rises 3 cycles after last key_valid (CHECK_WAIT=2). It stays high 50 cycles, then lock_clear pulses once and ready=1.
- Correct code, then submit on the 5th OPEN cycle → door_open drops, lock_clear on the next cycle, IDLE one cycle later, fail_count=0.
- lock_error after the 2nd bit, three times in a row → fail_count steps 1,2,3. After the third failure, alarm=1 for 200 cycles, and key_valid during lockout produces no lock_bit_valid. After lockout, fail_count=0 and ready=1.
- Two failures, then a correct code → fail_count returns to 0 and a subsequent failure yields fail_count=1 (no lockout).
- submit and key_valid in the same cycle after the 1st bit → abort: no forward, lock_clear pulse, fail_count unchanged.
- reset asserted mid-ENTRY and mid-LOCKOUT → all outputs immediately at reset values. A fresh correct code then unlocks normally.
